// File: rtl/bram_copy_seq.sv
// Sequencer that optionally fills BRAM A, then copies A->B through a read-latency delay line.
// Optional build macro BRAM_COPY_SEQ_AUTORUN_EN: DONE restarts the next pass instead of idling.
module bram_copy_seq #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              ena_A,
  output logic              wea_A,
  output logic [ADDR_W-1:0] addra_A,
  output logic              ena_B,
  output logic              wea_B,
  output logic [ADDR_W-1:0] addra_B,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FILL, COPY, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              mode_q, mode_nxt;
  logic              in_pass;
  logic              kill;
  logic              rd;

  logic              dl_v [RD_LAT];
  logic [ADDR_W-1:0] dl_a [RD_LAT];

  assign in_pass = (state == FILL) || (state == COPY) || (state == DRAIN);
  assign kill    = abort && in_pass;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          mode_nxt  = mode;
          state_nxt = mode ? COPY : FILL;
        end
      end
      FILL:  if (cnt == LAST_ADDR)  state_nxt = COPY;
      COPY:  if (cnt == LAST_ADDR)  state_nxt = DRAIN;
      DRAIN: if (cnt == LAST_DRAIN) state_nxt = DONE;
      DONE: begin
`ifdef BRAM_COPY_SEQ_AUTORUN_EN
        state_nxt = abort ? IDLE : (mode_q ? COPY : FILL);
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
    // One counter serves every phase: it restarts at 0 on each state change.
    cnt_nxt = ((state_nxt == state) && in_pass) ? cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Outputs are a registered decode of the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ena_A   <= 1'b0;
      wea_A   <= 1'b0;
      addra_A <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ena_A   <= !kill && ((state == FILL) || (state == COPY));
      wea_A   <= !kill && (state == FILL);
      addra_A <= (!kill && ((state == FILL) || (state == COPY))) ? cnt : '0;
      busy    <= !kill && in_pass;
      done    <= (state == DONE);
    end
  end

  assign rd = ena_A && !wea_A;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
      end
    end else if (kill) begin
      for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
      end
    end else begin
      dl_v[0] <= rd;
      dl_a[0] <= rd ? addra_A : '0;
      for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
    end
  end

  assign ena_B   = dl_v[RD_LAT-1];
  assign wea_B   = dl_v[RD_LAT-1];
  assign addra_B = dl_a[RD_LAT-1];

endmodule

// File: tb/tb_bram_copy_seq.sv
// Bench for bram_copy_seq: two instances (32/1 and 20/2) checked cycle by cycle
// against an arithmetic model of the pass timeline.
module tb_bram_copy_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, mode0 = 1'b0, abort0 = 1'b0;
  logic       ena_A0, wea_A0, ena_B0, wea_B0, busy0, done0;
  logic [4:0] addra_A0, addra_B0;
  logic       start1 = 1'b0, mode1 = 1'b0, abort1 = 1'b0;
  logic       ena_A1, wea_A1, ena_B1, wea_B1, busy1, done1;
  logic [4:0] addra_A1, addra_B1;

  bram_copy_seq #(.ADDR_W(5), .DEPTH(32), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .abort(abort0),
    .ena_A(ena_A0), .wea_A(wea_A0), .addra_A(addra_A0),
    .ena_B(ena_B0), .wea_B(wea_B0), .addra_B(addra_B0),
    .busy(busy0), .done(done0));

  bram_copy_seq #(.ADDR_W(5), .DEPTH(20), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .abort(abort1),
    .ena_A(ena_A1), .wea_A(wea_A1), .addra_A(addra_A1),
    .ena_B(ena_B1), .wea_B(wea_B1), .addra_B(addra_B1),
    .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;
  int max_addr1 = 0;

  typedef struct {
    int sel;
    bit mode;
    int abort_at;
    int restart_at;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input int k, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit s, input bit m, input bit a);
    if (sel == 0) begin start0 = s; mode0 = m; abort0 = a; end
    else          begin start1 = s; mode1 = m; abort1 = a; end
  endtask

  function automatic logic [15:0] obs(input int sel);
    if (sel == 0) return {ena_A0, wea_A0, addra_A0, ena_B0, wea_B0, addra_B0, busy0, done0};
    return {ena_A1, wea_A1, addra_A1, ena_B1, wea_B1, addra_B1, busy1, done1};
  endfunction

  // Expected outputs k cycles after the start edge (k=0 is the cycle right after it).
  function automatic logic [15:0] model(input int d, input int rl, input bit m, input int ka, input int k);
    int f, l, j;
    logic ea, wa, eb, bs, dn;
    logic [4:0] aa, ab;
    f = m ? 0 : d;
    l = f + d + rl + 1;
    ea = 1'b0; wa = 1'b0; eb = 1'b0; aa = '0; ab = '0;
    if (ka >= 0 && k > ka) return '0;
    bs = (k >= 1) && (k <= l - 1);
    dn = (k == l);
    if (k - 1 >= 0 && k - 1 < f) begin
      ea = 1'b1; wa = 1'b1; aa = 5'(k - 1);
    end else if (k - 1 >= f && k - 1 < f + d) begin
      ea = 1'b1; aa = 5'(k - 1 - f);
    end
    j = k - rl - 1;
    if (j >= f && j < f + d) begin
      eb = 1'b1; ab = 5'(j - f);
    end
    return {ea, wa, aa, eb, eb, ab, bs, dn};
  endfunction

  // Called at a negedge with the DUT idle; returns there with the DUT idle again.
  task automatic run_pass(input string name, input int sel, input bit m, input int ka,
                          input int ks, input int exp_done);
    int d, rl, l, done_at;
    logic [15:0] got;
    d  = (sel == 0) ? 32 : 20;
    rl = (sel == 0) ? 1 : 2;
    l  = (m ? 0 : d) + d + rl + 1;
    done_at = -1;
    drive(sel, 1'b1, m, 1'b0);
    @(posedge clk);
    for (int k = 0; k <= l + 1; k++) begin
      @(negedge clk);
      drive(sel, 1'b0, m, 1'b0);
      got = obs(sel);
      chk(name, k, got, model(d, rl, m, ka, k));
      if (got[0] === 1'b1) done_at = k;
      if (sel == 1) begin
        if (got[15] && int'(got[13:9]) > max_addr1) max_addr1 = int'(got[13:9]);
        if (got[8]  && int'(got[6:2])  > max_addr1) max_addr1 = int'(got[6:2]);
      end
      if (k == ka || k == ks) drive(sel, k == ks, m, k == ka);
    end
    chk_i({name, "_done_at"}, done_at, exp_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int quiet_bad;

    vecs[0] = '{0, 1'b0, -1, -1, 66};
    vecs[1] = '{1, 1'b1, -1, -1, 23};
    vecs[2] = '{1, 1'b0, -1, 10, 43};
    vecs[3] = '{0, 1'b0, 43, -1, -1};
    vecs[4] = '{0, 1'b1, -1, 20, 34};
    vecs[5] = '{1, 1'b0, 5, 3, -1};
    vecs[6] = '{1, 1'b1, 21, -1, -1};
    vecs[7] = '{0, 1'b1, -1, 33, 34};

    repeat (3) @(negedge clk);
    chk("reset0", 0, obs(0), '0);
    chk("reset1", 0, obs(1), '0);
    rst = 1'b1;

    // abort and start together in IDLE: nothing happens
    drive(0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0);
      chk("abort_start_idle", k, obs(0), '0);
    end

`ifndef BRAM_COPY_SEQ_AUTORUN_EN
    for (int i = 0; i < 8; i++)
      run_pass($sformatf("vec%0d", i), vecs[i].sel, vecs[i].mode, vecs[i].abort_at,
               vecs[i].restart_at, vecs[i].exp_done);

    for (int i = 0; i < 10; i++) begin
      int sel, l, ka, ks;
      bit m;
      sel = int'($urandom_range(1, 0));
      m   = 1'($urandom_range(1, 0));
      l   = (m ? 0 : (sel == 0 ? 32 : 20)) + (sel == 0 ? 32 : 20) + (sel == 0 ? 1 : 2) + 1;
      ka  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(l - 2, 0)) : -1;
      ks  = ($urandom_range(1, 0) == 1) ? int'($urandom_range((ka >= 0) ? ka : l - 1, 0)) : -1;
      run_pass($sformatf("rnd%0d", i), sel, m, ka, ks, (ka < 0) ? l : -1);
    end
    chk_i("max_addr_d20", max_addr1, 19);
`else
    begin
      int n_done;
      n_done = 0;
      drive(0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      for (int k = 0; k <= 200; k++) begin
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        if (done0 !== ((k > 0) && (k % 66 == 0))) begin
          errors++;
          $display("FAIL autorun_done k=%0d got=%b", k, done0);
        end
        if (done0 === 1'b1) n_done++;
        if (k == 200) drive(0, 1'b0, 1'b0, 1'b1);
      end
      checks++;
      chk_i("autorun_count", n_done, 3);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("autorun_abort", k, obs(0), '0);
      end
    end
`endif

    // asynchronous reset in the middle of FILL
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_busy", 0, obs(0), {2'b11, 5'd8, 2'b00, 5'd0, 1'b1, 1'b0});
    rst = 1'b0;
    #1;
    chk("async_rst", 0, obs(0), '0);
    repeat (3) @(negedge clk);
    quiet_bad = 0;
    if (obs(0) !== '0) quiet_bad++;
    rst = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (obs(0) !== '0) quiet_bad++;
    end
    chk_i("no_done_after_rst", quiet_bad, 0);
`ifndef BRAM_COPY_SEQ_AUTORUN_EN
    run_pass("post_rst", 0, 1'b0, -1, -1, 66);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_copy_seq.md
BRAM_COPY_SEQ -- requirements
Module: bram_copy_seq

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, meaning the address width of both BRAM ports.
REQ-002 The module SHALL have parameter DEPTH, default 32, meaning words per pass (legal range 2..2^ADDR_W).
REQ-003 The module SHALL have parameter RD_LAT, default 1, meaning the BRAM A read latency in cycles (legal values 1 or 2).
REQ-004 The module SHALL have the following ports, listed as name, direction, width, meaning:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a pass; sampled in IDLE only.
- mode  input  1  0 = fill A then copy A->B; 1 = copy only. Sampled with start.
- abort  input  1  synchronous cancel of a running pass.
- ena_A  output  1  BRAM A port enable.
- wea_A  output  1  BRAM A write enable.
- addra_A  output  ADDR_W  BRAM A address.
- ena_B  output  1  BRAM B port enable.
- wea_B  output  1  BRAM B write enable.
- addra_B  output  ADDR_W  BRAM B address.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse when a pass completes.
REQ-005 All outputs SHALL be registered.

Function
REQ-006 The FSM SHALL have the states IDLE, FILL, COPY, DRAIN and DONE.
REQ-007 In IDLE, a sampled start=1 SHALL move the FSM to FILL when mode=0, or to COPY when mode=1, on the next edge.
REQ-008 FILL SHALL last DEPTH cycles, with ena_A=1, wea_A=1 and addra_A stepping 0,1,...,DEPTH-1, then move to COPY.
REQ-009 COPY SHALL last DEPTH cycles, with ena_A=1, wea_A=0 and addra_A stepping 0..DEPTH-1, then move to DRAIN.
REQ-010 A read of addra_A=k issued in COPY SHALL produce ena_B=1, wea_B=1 and addra_B=k exactly RD_LAT cycles later, using a RD_LAT-deep valid/address delay line.
REQ-011 DRAIN SHALL last RD_LAT cycles, completing the B writes still in flight, then move to DONE.
REQ-012 DONE SHALL last one cycle, with done=1 and busy=0, then return to IDLE.
REQ-013 busy SHALL be 1 in FILL, COPY and DRAIN, and 0 in IDLE and DONE.
REQ-014 Both address counters SHALL be ADDR_W bits wide and SHALL wrap from DEPTH-1 to 0; no address >= DEPTH is ever driven.
REQ-015 Whenever a port's enable is 0, its address SHALL be driven to 0.
REQ-016 start SHALL be ignored while busy=1 or in DONE; no request is queued.
REQ-017 abort=1 at an edge in FILL, COPY or DRAIN SHALL force IDLE on that edge, drive every output to 0 in the following cycle, flush the delay line, and suppress done.
REQ-018 When abort and start are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-019 Latency from the start edge to the done cycle SHALL be 2*DEPTH+RD_LAT+1 cycles for mode 0 and DEPTH+RD_LAT+1 cycles for mode 1.

Reset
REQ-020 rst=0 SHALL immediately, and asynchronously, force IDLE, clear all counters and the delay line, and drive every output to 0.
REQ-021 Reset asserted mid-pass SHALL discard the pass; no done SHALL follow reset release.
REQ-022 The first start SHALL be sampled on the first rising edge after rst returns to 1.

Configuration
REQ-023 With macro BRAM_COPY_SEQ_AUTORUN_EN defined, DONE SHALL return to FILL or COPY (according to the last sampled mode) instead of IDLE, repeating passes until abort or reset; done still pulses once per pass.
REQ-024 Without BRAM_COPY_SEQ_AUTORUN_EN, DONE SHALL always return to IDLE and every pass SHALL require a new start.

Verification
REQ-025 Scenario: defaults, mode=0, start pulse -> addra_A is 0..31 with wea_A=1, then 0..31 with wea_A=0; addra_B is 0..31 with wea_B=1, one cycle behind the reads; done is high exactly 66 cycles after the start edge.
REQ-026 Scenario: mode=1, RD_LAT=2 -> no cycle with wea_A=1; the first B write is addra_B=0, two cycles after addra_A=0; done at cycle 35.
REQ-027 Scenario: DEPTH=20, ADDR_W=5 -> addresses wrap 19->0; the value 20 is never driven on either port.
REQ-028 Scenario: abort during COPY at addra_A=10 -> all outputs 0 the next cycle; no done; a subsequent start runs a clean full pass.
REQ-029 Scenario: start re-pulsed during busy, and abort+start together in IDLE -> both ignored; busy and done are unchanged.
REQ-030 Scenario: rst=0 mid-FILL, and AUTORUN build -> outputs go to 0 without a clock edge; the AUTORUN build shows done every 66 cycles until abort.
